// File: rtl/usb_key_sched_pkg.sv
// usb_key_sched_pkg
//   Shared types for the HID key scheduler: keycode type, pacing FSM states
//   and the "no key" code that requesters use to signal nothing to press.
//   No ports.

package usb_key_sched_pkg;

  typedef logic [15:0] keycode_t;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } sched_state_t;

  localparam keycode_t KEY_NONE = 16'h0000;

endpackage

// File: rtl/usb_key_fifo.sv
// usb_key_fifo
//   Synchronous keycode FIFO. Head entry is presented combinationally on
//   rdata; pop advances it. Push while full and pop while empty are ignored.
// Ports
//   clk    in   core clock
//   rstn   in   async active-low reset, empties the FIFO
//   push   in   write wdata at the tail
//   pop    in   drop the head entry
//   wdata  in   keycode to store
//   rdata  out  head keycode (valid when !empty)
//   empty  out  no entries
//   full   out  DEPTH entries
//   count  out  entries currently stored

module usb_key_fifo
  import usb_key_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  keycode_t                 wdata,
  output keycode_t                 rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  keycode_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/usb_hid_key_scheduler.sv
// usb_hid_key_scheduler
//   Collects keycodes from NREQ requesters (round-robin), queues them and
//   feeds them to usb_hid_top one press at a time, at least GAP_CYCLES apart.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a queued key and enable; pops head when both true
//   GAP   | key_request just pulsed; down-counting the inter-press spacing
//
// Ports
//   clk          in   60 MHz core clock
//   rstn         in   async active-low reset
//   enable       in   1 = issue keys, 0 = hold the queue
//   req_valid    in   per-requester keycode valid
//   req_key      in   per-requester keycode, slice [16*i +: 16]
//   req_ready    out  per-requester accept (valid & ready = transfer)
//   key_value    out  keycode presented to usb_hid_top
//   key_request  out  one-cycle press strobe
//   fifo_count   out  entries queued
//   reject_cnt   out  saturating count of discarded keycode-0 requests

module usb_hid_key_scheduler
  import usb_key_sched_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 1200000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*16-1:0]            req_key,
  output logic [NREQ-1:0]               req_ready,
  output logic [15:0]                   key_value,
  output logic                          key_request,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   reject_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 2);

  function automatic logic [IW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant_idx;
  logic           grant_found;
  keycode_t       grant_key;
  logic           grant_zero;
  logic           transfer;

  logic           fifo_push;
  logic           fifo_pop;
  keycode_t       fifo_rdata;
  logic           fifo_empty;
  logic           fifo_full;

  sched_state_t   state_q;
  sched_state_t   state_d;
  logic           issue;
  logic [CW-1:0]  gap_cnt;
  logic           enable_q;

  // Arbiter: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[wrap_idx(int'(rr_ptr), i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(int'(rr_ptr), i);
      end
    end
  end

  assign grant_key  = req_key[int'(grant_idx)*16 +: 16];
  assign grant_zero = (grant_key == KEY_NONE);
  // A zero keycode never takes a slot, so it is accepted even when full.
  assign transfer   = grant_found & (~fifo_full | grant_zero);
  assign fifo_push  = transfer & ~grant_zero;
  assign fifo_pop   = issue;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr     <= '0;
      reject_cnt <= '0;
    end else if (transfer) begin
      rr_ptr <= wrap_idx(int'(grant_idx), 1);
      if (grant_zero && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
    end
  end

  usb_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (grant_key),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // enable comes from application logic; it is registered once before the
  // FSM looks at it, so a re-raised enable issues the next press two cycles later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) enable_q <= 1'b0;
    else       enable_q <= enable;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q && !fifo_empty) begin
          issue   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // GAP lasts GAP_CYCLES-1 cycles and the pop in IDLE adds one more, giving
  // exactly GAP_CYCLES between strobes while keys keep coming.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      gap_cnt     <= '0;
      key_request <= 1'b0;
      key_value   <= '0;
    end else begin
      state_q     <= state_d;
      key_request <= issue;
      if (issue) begin
        gap_cnt   <= GAP_LOAD;
        key_value <= fifo_rdata;
      end else if (state_q == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_usb_hid_key_scheduler.sv
// tb_usb_hid_key_scheduler
//   Directed bench for usb_hid_key_scheduler with NREQ=2, FIFO_DEPTH=4,
//   GAP_CYCLES=8. Inputs change and outputs are sampled just after the
//   falling edge; "window" N is the half-open interval after the Nth sample.

module tb_usb_hid_key_scheduler;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [1:0]  req_valid;
  logic [31:0] req_key;
  logic [1:0]  req_ready;
  logic [15:0] key_value;
  logic        key_request;
  logic [2:0]  fifo_count;
  logic [15:0] reject_cnt;

  int n_total = 0;
  int n_bad   = 0;

  usb_hid_key_scheduler #(
    .NREQ       (2),
    .FIFO_DEPTH (4),
    .GAP_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_key     (req_key),
    .req_ready   (req_ready),
    .key_value   (key_value),
    .key_request (key_request),
    .fifo_count  (fifo_count),
    .reject_cnt  (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] v, input logic [15:0] k0, input logic [15:0] k1);
    req_valid = v;
    req_key   = {k1, k0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    set_req(2'b00, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    step();
    step();
  endtask

  // n windows with no strobe expected
  task automatic run_quiet(input int n, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (key_request) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  task automatic expect_pulse(input int gap, input logic [15:0] val, input string tag);
    run_quiet(gap - 1, {tag, "_quiet"});
    step();
    check({tag, "_req"}, key_request, 1);
    check({tag, "_val"}, key_value, val);
  endtask

  initial begin
    rstn   = 1'b0;
    enable = 1'b1;
    set_req(2'b00, 16'h0, 16'h0);
    #1;
    check("rst_key_value", key_value, 0);
    check("rst_key_request", key_request, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_reject_cnt", reject_cnt, 0);
    do_reset();

    // 1: single key latency
    set_req(2'b01, 16'h0004, 16'h0);
    #1;
    check("t1_ready", req_ready, 2'b01);
    step();
    set_req(2'b00, 16'h0, 16'h0);
    check("t1_req_t1", key_request, 0);
    check("t1_count_t1", fifo_count, 1);
    step();
    check("t1_req_t2", key_request, 1);
    check("t1_val_t2", key_value, 16'h0004);
    check("t1_count_t2", fifo_count, 0);
    step();
    check("t1_req_t3", key_request, 0);
    check("t1_val_hold", key_value, 16'h0004);

    // 2: round robin with two continuous requesters
    do_reset();
    set_req(2'b11, 16'h000A, 16'h000B);
    for (int w = 0; w < 20; w++) begin
      logic [1:0] exp_rdy;
      #1;
      if (w <= 10) begin
        if (w < 5)       exp_rdy = (w % 2 == 0) ? 2'b01 : 2'b10;
        else if (w < 10) exp_rdy = 2'b00;
        else             exp_rdy = 2'b10;
        check($sformatf("t2_ready_w%0d", w), req_ready, exp_rdy);
      end
      check($sformatf("t2_req_w%0d", w), key_request, (w == 2 || w == 10 || w == 18) ? 1 : 0);
      if (w == 2 || w == 18) check($sformatf("t2_val_w%0d", w), key_value, 16'h000A);
      if (w == 10)           check("t2_val_w10", key_value, 16'h000B);
      step();
    end
    set_req(2'b00, 16'h0, 16'h0);

    // 3: fill while disabled, zero accepted when full, then drain in order
    enable = 1'b0;
    do_reset();
    for (int w = 0; w < 4; w++) begin
      set_req(2'b01, 16'h0004 + 16'(w), 16'h0);
      #1;
      check($sformatf("t3_ready_w%0d", w), req_ready, 2'b01);
      step();
    end
    set_req(2'b11, 16'h0008, 16'h0000);
    #1;
    check("t3_count_full", fifo_count, 4);
    check("t3_zero_when_full", req_ready, 2'b10);
    enable = 1'b1;
    step();
    set_req(2'b01, 16'h0008, 16'h0);
    #1;
    check("t3_ready_full", req_ready, 2'b00);
    check("t3_reject", reject_cnt, 1);
    check("t3_req_w5", key_request, 0);
    step();
    check("t3_req_w6", key_request, 1);
    check("t3_val_w6", key_value, 16'h0004);
    check("t3_ready_w6", req_ready, 2'b01);
    step();
    set_req(2'b00, 16'h0, 16'h0);
    #1;
    check("t3_count_w7", fifo_count, 4);
    run_quiet(6, "t3_p05_quiet");
    step();
    check("t3_p05_req", key_request, 1);
    check("t3_p05_val", key_value, 16'h0005);
    expect_pulse(8, 16'h0006, "t3_p06");
    expect_pulse(8, 16'h0007, "t3_p07");
    expect_pulse(8, 16'h0008, "t3_p08");
    check("t3_count_end", fifo_count, 0);
    run_quiet(10, "t3_no_more");

    // 4: zero keycode discarded
    do_reset();
    set_req(2'b10, 16'h0, 16'h0000);
    #1;
    check("t4_ready_zero", req_ready, 2'b10);
    step();
    set_req(2'b10, 16'h0, 16'h0005);
    #1;
    check("t4_reject", reject_cnt, 1);
    check("t4_count_w1", fifo_count, 0);
    check("t4_ready_05", req_ready, 2'b10);
    step();
    set_req(2'b00, 16'h0, 16'h0);
    check("t4_count_peak", fifo_count, 1);
    step();
    check("t4_req", key_request, 1);
    check("t4_val", key_value, 16'h0005);
    check("t4_count_end", fifo_count, 0);
    run_quiet(12, "t4_only_one");
    check("t4_reject_end", reject_cnt, 1);

    // 5: reset during GAP with keys queued
    do_reset();
    for (int w = 0; w < 4; w++) begin
      set_req(2'b01, 16'h0011 + 16'(w), 16'h0);
      #1;
      check($sformatf("t5_ready_w%0d", w), req_ready, 2'b01);
      step();
    end
    set_req(2'b00, 16'h0, 16'h0);
    check("t5_count_pre", fifo_count, 3);
    check("t5_val_pre", key_value, 16'h0011);
    rstn = 1'b0;
    #1;
    check("t5_rst_val", key_value, 0);
    check("t5_rst_req", key_request, 0);
    check("t5_rst_count", fifo_count, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_quiet(16, "t5_quiet_after_rst");
    check("t5_count_after", fifo_count, 0);
    set_req(2'b01, 16'h0021, 16'h0);
    step();
    set_req(2'b00, 16'h0, 16'h0);
    check("t5_new_req_t1", key_request, 0);
    step();
    check("t5_new_req_t2", key_request, 1);
    check("t5_new_val", key_value, 16'h0021);

    // 6: enable dropped during GAP
    do_reset();
    for (int w = 0; w < 3; w++) begin
      set_req(2'b01, 16'h0031 + 16'(w), 16'h0);
      step();
    end
    set_req(2'b00, 16'h0, 16'h0);
    step();
    check("t6_in_gap_req", key_request, 0);
    check("t6_val_first", key_value, 16'h0031);
    enable = 1'b0;
    run_quiet(20, "t6_held");
    check("t6_count_held", fifo_count, 2);
    check("t6_val_held", key_value, 16'h0031);
    enable = 1'b1;
    step();
    check("t6_req_e1", key_request, 0);
    step();
    check("t6_req_e2", key_request, 1);
    check("t6_val_e2", key_value, 16'h0032);

    // reject counter saturation
    do_reset();
    set_req(2'b01, 16'h0000, 16'h0);
    repeat (65534) step();
    check("sat_fffe", reject_cnt, 16'hFFFE);
    repeat (3) step();
    check("sat_ffff", reject_cnt, 16'hFFFF);
    check("sat_count", fifo_count, 0);
    set_req(2'b00, 16'h0, 16'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
